// File: rtl/alu_multicycle_pkg.sv
// Shared opcode and sequencer-state types for the multicycle ALU.
// The first ten opcodes keep the encodings used by the combinational ALU.
package alu_multicycle_pkg;

  typedef enum logic [3:0] {
    OP_SLL, OP_SRL, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO
  } alu_mop_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdstate_t;

  function automatic logic is_muldiv(alu_mop_t op);
    return op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// Iterative multiply/divide engine, one bit per cycle on operand magnitudes.
// {acc,sh} is the shared work register: product for mul, remainder/quotient for div.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_signed,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic             run, div_q, neg_lo, neg_hi, b_zero;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc, sh, mag, a_raw;
  logic [WIDTH-1:0] acc_nx, sh_nx, diff, mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted;
  logic [2*WIDTH-1:0] prod;
  logic             a_neg, b_neg;

  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;
  assign done  = run && (cnt == CW'(WIDTH-1));

  always_comb begin
    sum     = {1'b0, acc} + (sh[0] ? {1'b0, mag} : '0);
    shifted = {acc, sh[WIDTH-1]};
    // remainder < divisor, so the difference always fits in WIDTH bits
    diff    = shifted[WIDTH-1:0] - mag;
    acc_nx  = sum[WIDTH:1];
    sh_nx   = {sum[0], sh[WIDTH-1:1]};
    if (div_q) begin
      if (shifted >= {1'b0, mag}) begin
        acc_nx = diff;
        sh_nx  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        sh_nx  = {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    prod = neg_lo ? -{acc, sh} : {acc, sh};
    {hi, lo} = prod;
    if (div_q) begin
      lo = b_zero ? '1    : (neg_lo ? -sh  : sh);
      hi = b_zero ? a_raw : (neg_hi ? -acc : acc);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run <= 1'b0; div_q <= 1'b0; neg_lo <= 1'b0; neg_hi <= 1'b0; b_zero <= 1'b0;
      cnt <= '0; acc <= '0; sh <= '0; mag <= '0; a_raw <= '0;
    end else if (start) begin
      run    <= 1'b1;
      cnt    <= '0;
      acc    <= '0;
      div_q  <= is_div;
      mag    <= is_div ? mag_b : mag_a;
      sh     <= is_div ? mag_a : mag_b;
      neg_lo <= a_neg ^ b_neg;
      neg_hi <= is_div & a_neg;
      b_zero <= (b == '0);
      a_raw  <= a;
    end else if (run) begin
      acc <= acc_nx;
      sh  <= sh_nx;
      cnt <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered ALU with valid/ready handshake, iterative mul/div and HI/LO registers.
// Simple ops complete in one cycle; mul/div hold off new ops until HI/LO are written.
module alu_multicycle
  import alu_multicycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             n_flag,
  output logic             z_flag,
  output logic             v_flag,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int M = WIDTH - 1;

  mdstate_t         state_q, state_d;
  alu_mop_t         mop;
  logic             accept, md_start, md_done;
  logic [WIDTH-1:0] md_hi, md_lo, add_r, sub_r, alu_res;
  logic             alu_v;

  assign mop      = alu_mop_t'(op);
  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign md_start = accept && is_muldiv(mop);
  assign busy     = (state_q == MUL) || (state_q == DIV);

  muldiv_iter #(.WIDTH(WIDTH)) u_md (
    .clk(clk), .rst(rst), .start(md_start),
    .op_signed(mop == OP_MULT || mop == OP_DIV),
    .is_div(mop == OP_DIV || mop == OP_DIVU),
    .a(a), .b(b), .done(md_done), .hi(md_hi), .lo(md_lo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (md_start) state_d = (mop == OP_DIV || mop == OP_DIVU) ? DIV : MUL;
      MUL,
      DIV:     if (md_done) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign add_r = a + b;
  assign sub_r = a - b;

  always_comb begin
    alu_res = '0;
    alu_v   = 1'b0;
    case (mop)
      OP_SLL:  alu_res = a << b[SHW-1:0];
      OP_SRL:  alu_res = a >> b[SHW-1:0];
      OP_ADD: begin
        alu_res = add_r;
        alu_v   = (a[M] == b[M]) && (add_r[M] != a[M]);
      end
      OP_SUB: begin
        alu_res = sub_r;
        alu_v   = (a[M] != b[M]) && (sub_r[M] != a[M]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NOR:  alu_res = ~(a | b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // A mul/div accept only happens once the previous result is gone, so DONE never collides with a held output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0; n_flag <= 1'b0; z_flag <= 1'b0; v_flag <= 1'b0;
      hi <= '0; lo <= '0;
    end else if (state_q == DONE) begin
      out_valid <= 1'b1;
      result    <= md_lo;
      hi        <= md_hi;
      lo        <= md_lo;
      n_flag    <= md_lo[M];
      z_flag    <= (md_lo == '0);
      v_flag    <= 1'b0;
    end else if (accept && !is_muldiv(mop)) begin
      out_valid <= 1'b1;
      result    <= alu_res;
      n_flag    <= alu_res[M];
      z_flag    <= (alu_res == '0);
      v_flag    <= alu_v;
    end else if (accept || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: handshake, simple ops, mul/div corners, reset abort.
module tb_alu_multicycle;
  import alu_multicycle_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]   op;
  logic [W-1:0] a, b, result, hi, lo;
  logic         n_flag, z_flag, v_flag, busy;
  int           nchk = 0;
  int           nerr = 0;

  alu_multicycle #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .n_flag(n_flag),
    .z_flag(z_flag), .v_flag(v_flag), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // drive at a negedge, accept on the following posedge, return at the next negedge
  task automatic send(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    check("in_ready_before_send", in_ready, 1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, input int exp_cyc);
    int c;
    c = 1;
    while (!out_valid && c < 80) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_latency"}, c, exp_cyc);
  endtask

  initial begin
    int  c;
    logic seen;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_hilo", {hi, lo}, 0);
    check("rst_flags", {n_flag, z_flag, v_flag, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // ADD overflow
    send(OP_ADD, 32'h7FFF_FFFF, 32'h1);
    wait_out("add", 1);
    check("add_result", result, 32'h8000_0000);
    check("add_nzv", {n_flag, z_flag, v_flag}, 3'b101);
    @(negedge clk);
    check("add_consumed", out_valid, 0);

    // SUB with back-pressure
    out_ready = 1'b0;
    send(OP_SUB, 32'd5, 32'd5);
    for (int i = 0; i < 3; i++) begin
      check("sub_held_valid", out_valid, 1);
      check("sub_held_result", result, 0);
      check("sub_held_nzv", {n_flag, z_flag, v_flag}, 3'b010);
      check("sub_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    check("sub_in_ready_on_take", in_ready, 1);
    @(negedge clk);
    check("sub_taken", out_valid, 0);

    // shifts, compares, logic
    send(OP_SLL, 32'h1, 32'h21);
    wait_out("sll", 1);
    check("sll_result", result, 32'h2);
    send(OP_SRL, 32'h8000_0000, 32'd31);
    wait_out("srl", 1);
    check("srl_result", result, 32'h1);
    send(OP_SLT, 32'hFFFF_FFFF, 32'h1);
    wait_out("slt", 1);
    check("slt_result", result, 32'h1);
    send(OP_SLTU, 32'hFFFF_FFFF, 32'h1);
    wait_out("sltu", 1);
    check("sltu_result", {result, z_flag}, {32'h0, 1'b1});
    send(OP_NOR, 32'h0, 32'h0);
    wait_out("nor", 1);
    check("nor_result", {result, n_flag, v_flag}, {32'hFFFF_FFFF, 1'b1, 1'b0});
    send(OP_SUB, 32'h8000_0000, 32'h1);
    wait_out("sub_ovf", 1);
    check("sub_ovf_result", {result, n_flag, v_flag}, {32'h7FFF_FFFF, 1'b0, 1'b1});

    // MULT signed
    send(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_busy", {busy, in_ready}, 2'b10);
    wait_out("mult", 34);
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    check("mult_result", {result, n_flag, z_flag, v_flag}, {32'hFFFF_FFFA, 3'b100});
    check("mult_busy_done", busy, 0);

    send(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    wait_out("multu", 34);
    check("multu_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    // simple op leaves HI/LO alone
    send(OP_OR, 32'h0, 32'h0);
    wait_out("or", 1);
    check("or_keeps_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

    send(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_out("div", 34);
    check("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);

    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_out("div_min", 34);
    check("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    send(OP_DIVU, 32'd9, 32'd0);
    wait_out("divu0", 34);
    check("divu0_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);

    send(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_out("div0", 34);
    check("div0_hilo", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);

    send(OP_DIVU, 32'd9, 32'd0);
    wait_out("divu0b", 34);
    send(OP_MFHI, 32'h0, 32'h0);
    wait_out("mfhi", 1);
    check("mfhi_result", {result, v_flag}, {32'd9, 1'b0});
    send(OP_MFLO, 32'h0, 32'h0);
    wait_out("mflo", 1);
    check("mflo_result", {result, n_flag}, {32'hFFFF_FFFF, 1'b1});

    // reset in the middle of a MULT
    send(OP_MULT, 32'd5, 32'd7);
    repeat (9) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_hilo", {hi, lo}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_in_ready", {in_ready, busy}, 2'b10);
    seen = 1'b0;
    for (c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_out_valid", seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

endmodule
